gray_stream_src: RTL and testbench

- Transmit side of the gray-level symbol stream consumed by the histogram counter.
- Reads NUM_SYM symbols from a synchronous image memory and emits one symbol per cycle on gray_data/gray_valid.
- Signals end-of-stream with the terminal code: gray_valid=0 and gray_data=0.
- Waits for the counter's cnt_valid acknowledge, then reports done to the top-level controller.

---
 rtl/gray_stream_src.sv | 205 ++++++++++++++++++++
 tb/tb_gray_stream_src.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_stream_src.sv
// -----------------------------------------------------------------------------
// gray_stream_src
//
// Transmit side of the gray-level symbol stream feeding the histogram counter.
// Fetches NUM_SYM symbols from a synchronous image memory (one-cycle read
// latency), emits one symbol per cycle on gray_data/gray_valid, then drives the
// terminal code (gray_valid=0, gray_data=0) until the counter acknowledges with
// cnt_valid, and finally pulses done.
//
// Optional feature macro: SYM_RANGE_CHECK_EN
//   When defined, fetched symbols outside 1..6 are replaced by a bubble and
//   counted on the extra output bad_cnt (saturating at 255).
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   start      in   begin a frame (sampled in IDLE only)
//   hold       in   stall request; suppresses new memory reads
//   mem_rd     out  memory read strobe
//   mem_addr   out  memory read address [ADDR_W-1:0]
//   mem_data   in   read data, valid the cycle after mem_rd
//   gray_data  out  symbol to the counter (IDLE_CODE on bubbles, 0 = terminal)
//   gray_valid out  symbol qualifier
//   cnt_valid  in   counter done acknowledge (one-cycle pulse)
//   busy       out  high from start acceptance until the done edge
//   done       out  one-cycle completion pulse
//   bad_cnt    out  dropped-symbol count (SYM_RANGE_CHECK_EN only)
// -----------------------------------------------------------------------------
module gray_stream_src #(
    parameter int          NUM_SYM   = 100,
    parameter int          ADDR_W    = 7,
    parameter logic [7:0]  IDLE_CODE = 8'hFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              hold,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic [7:0]        gray_data,
    output logic              gray_valid,
    input  logic              cnt_valid,
    output logic              busy,
    output logic              done
`ifdef SYM_RANGE_CHECK_EN
    ,
    output logic [7:0]        bad_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_TERM,
        S_DONE
    } state_t;

    // rd_cnt must be able to hold NUM_SYM itself when NUM_SYM == 2**ADDR_W.
    localparam int               CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SYM - 1);

    state_t             state, state_n;
    logic [CNT_W-1:0]   rd_cnt, rd_cnt_n;
    logic               rd_d;            // mem_rd delayed: mem_data is valid now
    logic               mem_rd_n;
    logic [ADDR_W-1:0]  mem_addr_n;
    logic [7:0]         gray_data_n;
    logic               gray_valid_n;
    logic               busy_n;
    logic               done_n;
    logic               sym_ok;

`ifdef SYM_RANGE_CHECK_EN
    assign sym_ok = (mem_data >= 8'd1) && (mem_data <= 8'd6);
`else
    assign sym_ok = 1'b1;
`endif

    // -------------------------------------------------------------------------
    // Next-state and registered-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before the case so no path can
        // leave it unassigned, which would infer a latch.
        state_n      = state;
        rd_cnt_n     = rd_cnt;
        mem_rd_n     = 1'b0;
        mem_addr_n   = mem_addr;
        gray_data_n  = IDLE_CODE;
        gray_valid_n = 1'b0;
        busy_n       = busy;
        done_n       = 1'b0;

        // Symbol returning from a read issued two edges ago. A read already in
        // flight is emitted regardless of hold.
        if ((state == S_STREAM || state == S_DRAIN) && rd_d && sym_ok) begin
            gray_data_n  = mem_data;
            gray_valid_n = 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n  = S_STREAM;
                    busy_n   = 1'b1;
                    rd_cnt_n = '0;
                    // First read is issued at the acceptance edge so the first
                    // symbol appears two edges later.
                    if (!hold) begin
                        mem_rd_n   = 1'b1;
                        mem_addr_n = '0;
                        rd_cnt_n   = CNT_W'(1);
                        if (LAST_IDX == '0) begin
                            state_n = S_DRAIN;
                        end
                    end
                end
            end

            S_STREAM: begin
                if (!hold) begin
                    mem_rd_n   = 1'b1;
                    mem_addr_n = rd_cnt[ADDR_W-1:0];
                    rd_cnt_n   = rd_cnt + 1'b1;
                    if (rd_cnt == LAST_IDX) begin
                        state_n = S_DRAIN;
                    end
                end
            end

            S_DRAIN: begin
                // Pipeline empty: nothing read last cycle and nothing returning
                // now, so the terminal code follows the last symbol directly.
                if (!mem_rd && !rd_d) begin
                    gray_data_n = 8'h00;
                    state_n     = S_TERM;
                end
            end

            S_TERM: begin
                gray_data_n = 8'h00;
                if (cnt_valid) begin
                    gray_data_n = IDLE_CODE;
                    done_n      = 1'b1;
                    busy_n      = 1'b0;
                    state_n     = S_DONE;
                end
            end

            S_DONE: begin
                state_n = S_IDLE;
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            rd_cnt     <= '0;
            rd_d       <= 1'b0;
            mem_rd     <= 1'b0;
            mem_addr   <= '0;
            gray_data  <= IDLE_CODE;
            gray_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state      <= state_n;
            rd_cnt     <= rd_cnt_n;
            rd_d       <= mem_rd;
            mem_rd     <= mem_rd_n;
            mem_addr   <= mem_addr_n;
            gray_data  <= gray_data_n;
            gray_valid <= gray_valid_n;
            busy       <= busy_n;
            done       <= done_n;
        end
    end

`ifdef SYM_RANGE_CHECK_EN
    // Dropped-symbol counter: cleared when a frame is accepted, saturating.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bad_cnt <= '0;
        end else if (state == S_IDLE && start) begin
            bad_cnt <= '0;
        end else if ((state == S_STREAM || state == S_DRAIN) && rd_d && !sym_ok
                     && bad_cnt != 8'hFF) begin
            bad_cnt <= bad_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gray_stream_src.sv
`timescale 1ns/1ps
module tb_gray_stream_src;

    localparam int         NUM  = 4;
    localparam int         AW   = 7;
    localparam logic [7:0] IDLE = 8'hFF;

    logic          clk = 1'b0;
    logic          reset;
    logic          start, hold, cnt_valid;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic [7:0]    gray_data;
    logic          gray_valid;
    logic          busy, done;

    // Second instance for the single-symbol frame
    logic          start1, cnt_valid1;
    logic          hold1 = 1'b0;
    logic          mem_rd1;
    logic [0:0]    mem_addr1;
    logic [7:0]    mem_data1;
    logic [7:0]    gray_data1;
    logic          gray_valid1;
    logic          busy1, done1;

`ifdef SYM_RANGE_CHECK_EN
    logic [7:0] bad_cnt, bad_cnt1;
`endif

    gray_stream_src #(.NUM_SYM(NUM), .ADDR_W(AW), .IDLE_CODE(IDLE)) dut (
        .clk(clk), .reset(reset), .start(start), .hold(hold),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
        .gray_data(gray_data), .gray_valid(gray_valid), .cnt_valid(cnt_valid),
        .busy(busy), .done(done)
`ifdef SYM_RANGE_CHECK_EN
        , .bad_cnt(bad_cnt)
`endif
    );

    gray_stream_src #(.NUM_SYM(1), .ADDR_W(1), .IDLE_CODE(IDLE)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .hold(hold1),
        .mem_rd(mem_rd1), .mem_addr(mem_addr1), .mem_data(mem_data1),
        .gray_data(gray_data1), .gray_valid(gray_valid1), .cnt_valid(cnt_valid1),
        .busy(busy1), .done(done1)
`ifdef SYM_RANGE_CHECK_EN
        , .bad_cnt(bad_cnt1)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous image memories (one-cycle read latency)
    logic [7:0] mem  [0:(1<<AW)-1];
    logic [7:0] mem1 [0:1];
    initial begin
        mem_data  = 8'h00;
        mem_data1 = 8'h00;
    end
    always @(posedge clk) if (mem_rd)  mem_data  <= mem[mem_addr];
    always @(posedge clk) if (mem_rd1) mem_data1 <= mem1[mem_addr1];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference rule: which fetched symbols reach the stream
    function automatic bit sym_kept(input logic [7:0] v);
`ifdef SYM_RANGE_CHECK_EN
        return (v >= 8'd1) && (v <= 8'd6);
`else
        return !$isunknown(v);
`endif
    endfunction

    // ---------------------------------------------------------------- scoreboard
    logic [7:0] exp_q[$];
    logic [7:0] exp_val;

    always @(negedge clk) begin
        if (!reset) begin
            if (gray_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_symbol: got %0h expected none", gray_data);
                end else begin
                    exp_val = exp_q.pop_front();
                    check("symbol", gray_data, exp_val);
                end
            end else if (gray_data == 8'h00) begin
                // terminal code may only follow every expected symbol
                check("term_after_all_symbols", exp_q.size(), 0);
            end else begin
                check("bubble_code", gray_data, IDLE);
            end
        end
    end

    // ---------------------------------------------------------------- frame driver
    // Called just after a clock edge. hmask bit k is the hold value sampled at Ek.
    task automatic run_frame(input string tag, input logic [63:0] hmask, input int cnt_wait,
                             input bit cv_in_stream, input bit start_in_term);
        int k, first_v, term_k, drops;
        drops = 0;
        for (int i = 0; i < NUM; i++) begin
            if (sym_kept(mem[i])) exp_q.push_back(mem[i]);
            else drops++;
        end

        start = 1'b1;
        hold  = hmask[0];
        @(posedge clk); #1;                       // after E0
        start = 1'b0;
        k = 0;
        check({tag, "_busy_after_start"}, busy, 1);
        if (!hmask[0]) begin
            check({tag, "_first_rd"}, mem_rd, 1);
            check({tag, "_first_addr"}, mem_addr, 0);
        end

        first_v = -1;
        term_k  = -1;
        while (term_k < 0 && k < 200) begin
            hold      = (k + 1 < 64) ? hmask[k+1] : 1'b0;
            cnt_valid = cv_in_stream && (k == 0);
            @(posedge clk); #1;
            k++;
            if (gray_valid && first_v < 0) first_v = k;
            if (!gray_valid && gray_data == 8'h00) term_k = k;
        end
        cnt_valid = 1'b0;
        hold      = 1'b0;

        if (term_k < 0) begin
            checks++;
            errors++;
            $display("FAIL %s_terminal_timeout: got none expected terminal within 200 cycles", tag);
        end else if (hmask == 64'd0) begin
            check({tag, "_term_edge"}, term_k, NUM + 2);
            if (sym_kept(mem[0])) check({tag, "_first_valid_edge"}, first_v, 2);
        end

        for (int j = 0; j < cnt_wait; j++) begin
            start = start_in_term && (j == 0);
            @(posedge clk); #1;
        end
        start = 1'b0;
        check({tag, "_term_held_valid"}, gray_valid, 0);
        check({tag, "_term_held_data"}, gray_data, 8'h00);
        check({tag, "_term_busy"}, busy, 1);

        cnt_valid = 1'b1;
        @(posedge clk); #1;
        cnt_valid = 1'b0;
        check({tag, "_done_pulse"}, done, 1);
        check({tag, "_done_busy"}, busy, 0);
        check({tag, "_done_data"}, gray_data, IDLE);
        check({tag, "_done_valid"}, gray_valid, 0);
        check({tag, "_all_emitted"}, exp_q.size(), 0);
`ifdef SYM_RANGE_CHECK_EN
        check({tag, "_bad_cnt"}, bad_cnt, drops);
`endif
        @(posedge clk); #1;
        check({tag, "_done_single"}, done, 0);
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_idle_data"}, gray_data, IDLE);
    endtask

    task automatic load4(input logic [7:0] a, b, c, d);
        mem[0] = a; mem[1] = b; mem[2] = c; mem[3] = d;
    endtask

    // ---------------------------------------------------------------- main
    initial begin
        reset = 1'b1; start = 1'b0; hold = 1'b0; cnt_valid = 1'b0;
        start1 = 1'b0; cnt_valid1 = 1'b0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
        mem1[0] = 8'h00; mem1[1] = 8'h00;
        #3;
        check("rst_mem_rd", mem_rd, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_valid", gray_valid, 0);
        check("rst_data", gray_data, IDLE);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        #9 reset = 1'b0;
        @(posedge clk); #1;

        // Basic frame, cnt_valid sampled at E8
        load4(8'd1, 8'd2, 8'd3, 8'd6);
        run_frame("basic", 64'd0, 1, 1'b0, 1'b0);

        // hold at E2..E3
        run_frame("hold", 64'h0C, 1, 1'b0, 1'b0);

        // cnt_valid during STREAM and start during TERM are ignored
        run_frame("ignore", 64'd0, 2, 1'b1, 1'b1);

        // Async reset mid-STREAM
        load4(8'd4, 8'd5, 8'd6, 8'd1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        check("midrst_mem_rd", mem_rd, 0);
        check("midrst_mem_addr", mem_addr, 0);
        check("midrst_valid", gray_valid, 0);
        check("midrst_data", gray_data, IDLE);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        run_frame("replay", 64'd0, 0, 1'b0, 1'b0);

        // Out-of-range symbols (dropped only with the range check)
        load4(8'd0, 8'd3, 8'd7, 8'd5);
        run_frame("range", 64'd0, 1, 1'b0, 1'b0);

        // Single-symbol frame on the second instance
        mem1[0] = 8'($urandom_range(1, 6));
        start1 = 1'b1;
        @(posedge clk); #1;                       // E0
        start1 = 1'b0;
        @(posedge clk); #1;                       // E1
        check("one_e1_valid", gray_valid1, 0);
        @(posedge clk); #1;                       // E2
        check("one_e2_valid", gray_valid1, 1);
        check("one_e2_data", gray_data1, mem1[0]);
        @(posedge clk); #1;                       // E3
        check("one_e3_valid", gray_valid1, 0);
        check("one_e3_data", gray_data1, 8'h00);
        cnt_valid1 = 1'b1;
        @(posedge clk); #1;
        cnt_valid1 = 1'b0;
        check("one_done", done1, 1);
        check("one_busy", busy1, 0);
        check("one_idle_data", gray_data1, IDLE);

        // Randomized frames
        for (int f = 0; f < 24; f++) begin
            logic [63:0] hm;
            for (int i = 0; i < NUM; i++) begin
`ifdef SYM_RANGE_CHECK_EN
                mem[i] = 8'($urandom_range(0, 9));
`else
                mem[i] = 8'($urandom_range(0, 255));
`endif
            end
            hm = {$urandom, $urandom} & {$urandom, $urandom};
            if (f % 2 == 0) hm = 64'd0;
            run_frame($sformatf("rand%0d", f), hm, $urandom_range(0, 3),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
